p2s_rr_sched: RTL and testbench
===============================

P2S_RR_SCHED -- requirements
Module: p2s_rr_sched

Interface
REQ-001 The block SHALL have no parameters; requester count is fixed at 4 and word width at 4 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 req_i  input  4  per-requester request; bit k is requester k.
REQ-005 data_i  input  16  per-requester word; requester k uses bits [4k+3:4k].
REQ-006 gnt_o  output  4  one-hot grant; asserted for exactly the cycle in which a word is accepted.
REQ-007 serial_o  output  1  serialized data bit, LSB first.
REQ-008 valid_o  output  1  serial_o carries a valid bit this cycle.
REQ-009 sof_o  output  1  high with bit 0 of each word.
REQ-010 id_o  output  2  index of the requester whose word is on serial_o.
REQ-011 empty_o  output  1  high when no word is being shifted.

Function
REQ-012 The FSM SHALL have two states: IDLE and SHIFT, plus a 2-bit bit counter cnt.
REQ-013 A grant opportunity SHALL exist in IDLE, and in SHIFT when cnt==3.
REQ-014 At a grant opportunity with req_i!=0, gnt_o SHALL assert combinationally to one requester, chosen by round-robin.
- The granted word and its index SHALL load at that edge.
- The FSM SHALL enter SHIFT or stay in SHIFT, with cnt=0.
REQ-015 At a grant opportunity with req_i==0, gnt_o SHALL be 0.
- From SHIFT with cnt==3 the FSM SHALL return to IDLE.
REQ-016 gnt_o SHALL be 0 at all non-opportunity cycles, regardless of req_i.
REQ-017 Round-robin: after granting k, priority order SHALL be k+1, k+2, k+3, k (mod 4).
- The pointer SHALL update only on a grant.
REQ-018 In SHIFT the outputs SHALL be:
- valid_o=1 and serial_o=word[cnt].
- sof_o=(cnt==0).
- id_o=latched index.
- empty_o=0.
- cnt SHALL increment each cycle.
REQ-019 In IDLE the outputs SHALL be: valid_o=0, serial_o=0, sof_o=0, empty_o=1, with id_o holding its last value.
REQ-020 Latency: a grant at cycle N SHALL put bits 0..3 on cycles N+1..N+4.
REQ-021 Back-to-back grants SHALL produce continuous valid_o with no bubble.
REQ-022 Requesters SHALL hold req_i and data_i stable until granted.
- A request dropped before its grant SHALL be ignored and never partially sent.
REQ-023 Simultaneous requests SHALL resolve to exactly one grant per opportunity; gnt_o SHALL never have more than one bit set.
REQ-024 serial_o, valid_o, sof_o, id_o and empty_o SHALL be driven from registers only, with no combinational path from inputs.

Reset
REQ-025 Reset SHALL force, on the next edge:
- state=IDLE, cnt=0, shift register=0.
- round-robin pointer set so that requester 0 has highest priority.
REQ-026 Reset values of the outputs SHALL be: gnt_o=0, serial_o=0, valid_o=0, sof_o=0, id_o=0, empty_o=1.
REQ-027 gnt_o SHALL be 0 during any cycle in which reset is high.
REQ-028 Reset in mid-word SHALL abort the word; the remaining bits SHALL NOT be sent, and valid_o SHALL be 0 in the next cycle.

Verification
REQ-029 Single requester: req_i=0001 and data_i[3:0]=4'hA in IDLE.
- gnt_o=0001 for one cycle.
- The next 4 cycles SHALL show valid_o=1, serial_o=0,1,0,1, sof_o only on the first, id_o=0.
- empty_o SHALL then return to 1.
REQ-030 All requesters: req_i=1111 held, with data 1,2,3,4.
- Grants SHALL go in order 0,1,2,3,0.
- valid_o SHALL stay continuously high.
- Each later grant SHALL coincide with cnt==3.
REQ-031 Fairness: req_i=0101 held for 16 cycles.
- Grants SHALL alternate 0,2,0,2.
- Each requester SHALL send 2 words.
REQ-032 Reset mid-word: assert reset after 2 bits of a word from requester 2.
- The next cycle SHALL show valid_o=0 and empty_o=1.
- Then req_i=1010 SHALL grant requester 1 first.
REQ-033 Withdrawn request: req_i=0100 asserted only during a non-opportunity SHIFT cycle.
- No grant SHALL occur.
- After the current word the FSM SHALL go IDLE with empty_o=1.
REQ-034 Grant invariant: gnt_o SHALL be checked one-hot-or-zero every cycle over 1000 cycles of random req_i.

Source files
------------

// File: rtl/p2s_rr_sched_if.sv
// Request/grant and serial-output bundle of the 4-requester round-robin serializer.
// The master side drives requests and words; the slave side (the scheduler) answers.
interface p2s_rr_sched_if;
    logic [3:0]  req_i;
    logic [15:0] data_i;
    logic [3:0]  gnt_o;
    logic        serial_o;
    logic        valid_o;
    logic        sof_o;
    logic [1:0]  id_o;
    logic        empty_o;

    modport master (
        output req_i,
        output data_i,
        input  gnt_o,
        input  serial_o,
        input  valid_o,
        input  sof_o,
        input  id_o,
        input  empty_o
    );

    modport slave (
        input  req_i,
        input  data_i,
        output gnt_o,
        output serial_o,
        output valid_o,
        output sof_o,
        output id_o,
        output empty_o
    );
endinterface

// File: rtl/p2s_rr_sched.sv
// Round-robin arbiter over four requesters feeding a 4-bit parallel-to-serial shifter.
// A new word can be granted while idle or during the last bit of the current word.
module p2s_rr_sched (
    input  logic          clk,
    input  logic          reset,
    p2s_rr_sched_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state_reg;
    logic [1:0] cnt_reg;
    logic [2:0] shift_reg;
    logic [1:0] ptr_reg;
    logic [1:0] id_reg;
    logic       serial_reg;
    logic       valid_reg;
    logic       sof_reg;
    logic       empty_reg;

    logic [3:0] rot_req;
    logic [3:0] word_arr [4];
    logic [1:0] pick_off;
    logic       pick_any;
    logic [1:0] pick_idx;
    logic       opportunity;
    logic       grant;
    logic [3:0] grant_word;
    logic [1:0] ptr_next;

    // Requests rotated so that bit 0 is the requester currently holding top priority.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rot_req[gi]  = bus.req_i[ptr_reg + 2'(gi)];
            assign word_arr[gi] = bus.data_i[4*gi +: 4];
            assign bus.gnt_o[gi] = grant && (pick_idx == 2'(gi));
        end
    endgenerate

    always_comb begin
        pick_off = 2'd0;
        pick_any = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) begin
                pick_off = 2'(i);
                pick_any = 1'b1;
            end
        end
    end

    assign pick_idx    = ptr_reg + pick_off;
    assign opportunity = (state_reg == IDLE) || (cnt_reg == 2'd3);
    assign grant       = opportunity && pick_any && !reset;
    assign grant_word  = word_arr[pick_idx];
    assign ptr_next    = pick_idx + 2'd1;

    // Outputs are precomputed for the following cycle so every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 2'd0;
            shift_reg  <= 3'd0;
            ptr_reg    <= 2'd0;
            id_reg     <= 2'd0;
            serial_reg <= 1'b0;
            valid_reg  <= 1'b0;
            sof_reg    <= 1'b0;
            empty_reg  <= 1'b1;
        end else if (grant) begin
            state_reg  <= SHIFT;
            cnt_reg    <= 2'd0;
            shift_reg  <= grant_word[3:1];
            ptr_reg    <= ptr_next;
            id_reg     <= pick_idx;
            serial_reg <= grant_word[0];
            valid_reg  <= 1'b1;
            sof_reg    <= 1'b1;
            empty_reg  <= 1'b0;
        end else if (state_reg == SHIFT && cnt_reg != 2'd3) begin
            cnt_reg    <= cnt_reg + 2'd1;
            shift_reg  <= {1'b0, shift_reg[2:1]};
            serial_reg <= shift_reg[0];
            sof_reg    <= 1'b0;
        end else begin
            // Idle, or last bit sent with nobody waiting; id holds its last value.
            state_reg  <= IDLE;
            cnt_reg    <= 2'd0;
            shift_reg  <= 3'd0;
            serial_reg <= 1'b0;
            valid_reg  <= 1'b0;
            sof_reg    <= 1'b0;
            empty_reg  <= 1'b1;
        end
    end

    assign bus.serial_o = serial_reg;
    assign bus.valid_o  = valid_reg;
    assign bus.sof_o    = sof_reg;
    assign bus.id_o     = id_reg;
    assign bus.empty_o  = empty_reg;
endmodule

// File: tb/tb_p2s_rr_sched.sv
// Scoreboard bench for p2s_rr_sched: a word-level model predicts grants and the serial
// stream; a separate monitor pops expected bits whenever the DUT shows output.
module tb_p2s_rr_sched;
    logic clk = 1'b0;
    logic reset;

    p2s_rr_sched_if bus();

    p2s_rr_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       serial;
        logic       sof;
        logic [1:0] id;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   gnt_log[$];
    int   words_sent[4];
    int   m_ptr     = 0;
    int   m_rem     = 0;
    int   m_last_id = 0;
    bit   mon_en    = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: m_rem counts bits of the current word still on the wire (this cycle included).
    int         mk;
    int         m_exp_gnt;
    logic [3:0] mw;
    always @(negedge clk) begin
        m_exp_gnt = 0;
        if (reset) begin
            exp_q.delete();
            m_rem     = 0;
            m_ptr     = 0;
            m_last_id = 0;
        end else if (m_rem <= 1 && bus.req_i != 4'd0) begin
            mk = m_ptr;
            while (!bus.req_i[mk]) mk = (mk + 1) % 4;
            m_exp_gnt = 1 << mk;
            mw = bus.data_i[4*mk +: 4];
            for (int b = 0; b < 4; b++)
                exp_q.push_back(exp_t'{serial: mw[b], sof: (b == 0), id: 2'(mk)});
            m_ptr     = (mk + 1) % 4;
            m_last_id = mk;
            m_rem     = 4;
            $display("grant requester=%0d word=%h", mk, mw);
        end else if (m_rem > 0) begin
            m_rem--;
        end
        check("gnt", int'(bus.gnt_o), m_exp_gnt);
        check("gnt_onehot0", int'($onehot0(bus.gnt_o)), 1);
        if (bus.gnt_o != 4'd0) gnt_log.push_back($clog2(bus.gnt_o));
    end

    // Monitor: sampled 2 time units after the edge, while outputs are stable.
    exp_t me;
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            if (bus.valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    me = exp_q.pop_front();
                    check("serial", int'(bus.serial_o), int'(me.serial));
                    check("sof", int'(bus.sof_o), int'(me.sof));
                    check("id", int'(bus.id_o), int'(me.id));
                    check("empty_busy", int'(bus.empty_o), 0);
                    if (me.sof) words_sent[me.id]++;
                end
            end else begin
                check("bubble", exp_q.size(), 0);
                check("idle_serial", int'(bus.serial_o), 0);
                check("idle_sof", int'(bus.sof_o), 0);
                check("idle_empty", int'(bus.empty_o), 1);
                check("idle_id", int'(bus.id_o), m_last_id);
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic [15:0] d, input logic rs);
        bus.req_i  = r;
        bus.data_i = d;
        reset      = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'd0, 16'd0, 1'b0);
    endtask

    initial begin
        drive(4'd0, 16'd0, 1'b1);
        drive(4'd0, 16'd0, 1'b1);
        mon_en = 1'b1;
        check("reset_valid", int'(bus.valid_o), 0);
        check("reset_empty", int'(bus.empty_o), 1);
        check("reset_id", int'(bus.id_o), 0);

        // Single requester, word A
        gnt_log.delete();
        drive(4'b0001, 16'h000A, 1'b0);
        idle(6);
        check("single_grants", gnt_log.size(), 1);
        check("single_empty", int'(bus.empty_o), 1);

        // All requesters held: order 0,1,2,3,0 with continuous output
        drive(4'd0, 16'd0, 1'b1);
        gnt_log.delete();
        for (int i = 0; i < 17; i++) drive(4'b1111, 16'h4321, 1'b0);
        idle(6);
        check("all_count", gnt_log.size(), 5);
        for (int i = 0; i < 5 && i < gnt_log.size(); i++)
            check("all_order", gnt_log[i], i % 4);

        // Fairness between requesters 0 and 2
        drive(4'd0, 16'd0, 1'b1);
        gnt_log.delete();
        for (int i = 0; i < 4; i++) words_sent[i] = 0;
        for (int i = 0; i < 16; i++) drive(4'b0101, 16'($urandom), 1'b0);
        idle(6);
        check("fair_count", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check("fair_order", gnt_log[i], (i % 2) * 2);
        check("fair_words0", words_sent[0], 2);
        check("fair_words2", words_sent[2], 2);

        // Reset after two bits of a word from requester 2
        drive(4'd0, 16'd0, 1'b1);
        drive(4'b0100, 16'h0B00, 1'b0);
        drive(4'd0, 16'd0, 1'b0);
        drive(4'd0, 16'd0, 1'b1);
        check("abort_valid", int'(bus.valid_o), 0);
        check("abort_empty", int'(bus.empty_o), 1);
        gnt_log.delete();
        drive(4'b1010, 16'h5A00, 1'b0);
        idle(6);
        check("abort_next_count", gnt_log.size(), 1);
        if (gnt_log.size() > 0) check("abort_next_req", gnt_log[0], 1);

        // Request raised and withdrawn within a non-opportunity cycle
        drive(4'd0, 16'd0, 1'b1);
        drive(4'b0001, 16'h0005, 1'b0);
        gnt_log.delete();
        drive(4'b0100, 16'h0F00, 1'b0);
        idle(6);
        check("withdraw_grants", gnt_log.size(), 0);
        check("withdraw_empty", int'(bus.empty_o), 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 1000; i++)
            drive(4'($urandom), 16'($urandom), ($urandom_range(0, 99) == 0));
        idle(6);
        check("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
